fibo_host: RTL and testbench

- Initiator side of the Fibonacci calculator's start/count/done/data interface.
- Accepts a request (term index) over a valid/ready handshake, launches one calculator run, and waits for the calculator's done.
- Captures the result and returns it over a valid/ready response channel.
- Guards the calculator against indices below its minimum and against a hung run (timeout).

---
 rtl/fibo_host.sv | 118 +++++++++++
 tb/tb_fibo_host.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_host.sv
// fibo_host - initiator side of the Fibonacci calculator's start/count/done/data
// interface. It takes one term index per valid/ready request, launches one
// calculator run, waits for the calculator's done, then returns the result on
// a valid/ready response channel.
// Indices below MIN_COUNT are rejected locally. A run that does not finish
// within TIMEOUT_CYCLES WAIT cycles is reported as an error.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready/req_count   request channel (4-bit term index)
//   calc_start/calc_count           one-cycle start pulse and the index, held until the response is taken
//   calc_done/calc_data             calculator completion (level or pulse) and its result
//   rsp_valid/rsp_ready             response channel handshake
//   rsp_data/rsp_count/rsp_err      result (0 on error), its index, and the error flag
//   busy                            high whenever the host is not idle
module fibo_host #(
  parameter int MIN_COUNT      = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TW             = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_count,
  output logic       calc_start,
  output logic [3:0] calc_count,
  input  logic       calc_done,
  input  logic [3:0] calc_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [3:0] rsp_count,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]    MIN_C   = 4'(MIN_COUNT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          done_q;
  logic [TW-1:0] timer;
  logic          done_rise;

  // Edge detect: a done level left over from an earlier run cannot complete
  // the current one.
  assign done_rise = calc_done & ~done_q;
  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      done_q     <= 1'b0;
      timer      <= '0;
      calc_start <= 1'b0;
      calc_count <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_count  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done_q     <= calc_done;
      calc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            calc_count <= req_count;
            rsp_count  <= req_count;
            busy       <= 1'b1;
            if (req_count < MIN_C) begin
              // Rejected locally; the calculator never sees this index.
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              calc_start <= 1'b1;
              state      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Saturating so the count can never wrap back below the limit.
          if (timer != '1) timer <= timer + 1'b1;
          // Done is tested first so a result arriving on the last cycle wins.
          if (done_rise) begin
            rsp_data  <= calc_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timer == TO_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_host.sv
// Directed bench for fibo_host. The calculator is modelled inline: the main
// thread raises calc_done a fixed number of cycles after calc_start with a
// hand-picked result. Inputs change on the falling edge and outputs are
// sampled there.
module tb_fibo_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_count = '0;
  logic       calc_start;
  logic [3:0] calc_count;
  logic       calc_done = 1'b0;
  logic [3:0] calc_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic [3:0] rsp_count;
  logic       rsp_err;
  logic       busy;

  int errs = 0;
  int checks = 0;
  int starts = 0;

  fibo_host #(.MIN_COUNT(2), .TIMEOUT_CYCLES(16), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_count(req_count),
    .calc_start(calc_start), .calc_count(calc_count),
    .calc_done(calc_done), .calc_data(calc_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_count(rsp_count), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Start pulses seen by the calculator, sampled on the active edge.
  always @(posedge clk) if (calc_start === 1'b1) starts = starts + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge; returns one falling edge after the
  // accepting rising edge with req_valid already dropped.
  task automatic send(input logic [3:0] cnt);
    req_valid = 1'b1;
    req_count = cnt;
    chk("req_ready_before_send", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (rsp_valid !== 1'b1) chk("rsp_wait_expired", 0, 1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ack_rsp_valid_low", rsp_valid, 0);
    chk("ack_req_ready", req_ready, 1);
  endtask

  // Launch a valid index and have the calculator finish after dly cycles.
  task automatic run(input string tag, input logic [3:0] cnt, input int dly, input logic [3:0] res);
    int cyc;
    int s0;
    s0 = starts;
    send(cnt);
    chk({tag, "_calc_start"}, calc_start, 1);
    chk({tag, "_calc_count"}, calc_count, cnt);
    chk({tag, "_busy"}, busy, 1);
    repeat (dly) @(negedge clk);
    calc_done = 1'b1;
    calc_data = res;
    wait_rsp(cyc);
    chk({tag, "_rsp_data"}, rsp_data, res);
    chk({tag, "_rsp_count"}, rsp_count, cnt);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_one_start"}, starts - s0, 1);
  endtask

  initial begin
    int cyc;
    int bad;
    int s0;
    logic [3:0] d0;

    // Reset state while held low.
    #2;
    chk("rst_calc_start", calc_start, 0);
    chk("rst_calc_count", calc_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_count", rsp_count, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // Basic run: index 6, done 5 cycles after start, result 8.
    run("fib6", 4'd6, 5, 4'd8);
    ack();

    // calc_done stays high from the previous run: no completion until it
    // falls and rises again.
    send(4'd5);
    chk("stale_calc_start", calc_start, 1);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("stale_no_complete", bad, 0);
    calc_done = 1'b0;
    @(negedge clk);
    calc_done = 1'b1;
    calc_data = 4'd5;
    wait_rsp(cyc);
    chk("stale_rsp_data", rsp_data, 5);
    chk("stale_rsp_err", rsp_err, 0);
    chk("stale_rsp_count", rsp_count, 5);
    ack();
    calc_done = 1'b0;

    // Indices below the minimum: rejected without starting the calculator.
    for (int i = 1; i >= 0; i--) begin
      s0 = starts;
      send(4'(i));
      chk("rej_rsp_valid", rsp_valid, 1);
      chk("rej_rsp_err", rsp_err, 1);
      chk("rej_rsp_data", rsp_data, 0);
      chk("rej_rsp_count", rsp_count, i);
      chk("rej_no_start", starts - s0, 0);
      ack();
    end

    // Hung calculator: error after exactly 16 WAIT cycles.
    send(4'd7);
    chk("to_calc_start", calc_start, 1);
    wait_rsp(cyc);
    // cyc counts from the LAUNCH cycle; WAIT cycles are one fewer.
    chk("to_wait_cycles", cyc - 1, 16);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_count", rsp_count, 7);

    // Hold the response for 10 cycles with a competing request pending.
    s0 = starts;
    d0 = rsp_data;
    req_valid = 1'b1;
    req_count = 4'd3;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0
          || rsp_count !== 4'd7 || calc_count !== 4'd7) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_no_start", starts - s0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_rel_rsp_valid", rsp_valid, 0);
    chk("hold_rel_req_ready", req_ready, 1);
    chk("hold_rel_data_kept", rsp_data, d0);
    // The pending request is accepted on the next edge.
    @(negedge clk);
    req_valid = 1'b0;
    chk("next_calc_start", calc_start, 1);
    chk("next_calc_count", calc_count, 3);
    repeat (2) @(negedge clk);
    calc_done = 1'b1;
    calc_data = 4'd2;
    wait_rsp(cyc);
    chk("next_rsp_data", rsp_data, 2);
    chk("next_rsp_err", rsp_err, 0);
    ack();
    calc_done = 1'b0;

    // Reset during WAIT abandons the run immediately.
    send(4'd9);
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_calc_count", calc_count, 0);
    chk("arst_rsp_count", rsp_count, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_calc_start", calc_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    chk("arst_no_rsp", bad, 0);
    run("fib4", 4'd4, 3, 4'd3);
    ack();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
